// File: rtl/sort_output_collector.sv
// Output side of the switch sort network: splits the sorted tagged bus into one
// show-ahead FIFO per destination, drops duplicates and overflow, and counts the drops.
module sort_output_collector #(
   parameter int PORT_NUB   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORT_NUB*(1+$clog2(PORT_NUB)+DATA_WIDTH)-1:0] sort_in,
   output logic [PORT_NUB-1:0]              out_valid,
   input  logic [PORT_NUB-1:0]              out_ready,
   output logic [PORT_NUB*DATA_WIDTH-1:0]   out_data,
   output logic [15:0]                      drop_cnt
);

   localparam int DEST_W     = $clog2(PORT_NUB);
   localparam int WIDTH_PORT = 1 + DEST_W + DATA_WIDTH;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int SUM_W      = $clog2(PORT_NUB) + 1;

   function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [SUM_W-1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, acc} + 17'(inc);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic [PORT_NUB-1:0]   vld_p1;
   logic [DEST_W-1:0]     dest_p1 [PORT_NUB];
   logic [DATA_WIDTH-1:0] data_p1 [PORT_NUB];

   logic [PORT_NUB-1:0]   win_vld;
   logic [DATA_WIDTH-1:0] win_data [PORT_NUB];
   logic [PORT_NUB-1:0]   push;
   logic [PORT_NUB-1:0]   pop;
   logic [SUM_W-1:0]      n_vld;
   logic [SUM_W-1:0]      n_push;
   logic [SUM_W-1:0]      drop_now;

   logic [DATA_WIDTH-1:0] mem [PORT_NUB][FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr [PORT_NUB];
   logic [PTR_W-1:0]      rd_ptr [PORT_NUB];
   logic [CNT_W-1:0]      cnt    [PORT_NUB];

   // Stage 1: register the sorted bus; only the valid bits are reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < PORT_NUB; i++) begin
         dest_p1[i] <= sort_in[i*WIDTH_PORT + DATA_WIDTH +: DEST_W];
         data_p1[i] <= sort_in[i*WIDTH_PORT +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= '0;
      end else begin
         for (int i = 0; i < PORT_NUB; i++)
            vld_p1[i] <= sort_in[i*WIDTH_PORT + WIDTH_PORT - 1];
      end
   end

   // Stage 2: per-destination winner select, full check, and drop tally
   always_comb begin
      win_vld = '0;
      push    = '0;
      pop     = '0;
      n_vld   = '0;
      n_push  = '0;
      for (int d = 0; d < PORT_NUB; d++) begin
         win_data[d] = '0;
         for (int i = 0; i < PORT_NUB; i++) begin
            if (!win_vld[d] && vld_p1[i] && dest_p1[i] == DEST_W'(d)) begin
               win_vld[d]  = 1'b1;
               win_data[d] = data_p1[i];
            end
         end
      end
      for (int i = 0; i < PORT_NUB; i++)
         n_vld = n_vld + SUM_W'(vld_p1[i]);
      // Fullness is judged before any pop, so a pop never makes room for a same-cycle write
      for (int d = 0; d < PORT_NUB; d++) begin
         push[d] = win_vld[d] && (cnt[d] != CNT_W'(FIFO_DEPTH));
         pop[d]  = out_valid[d] && out_ready[d];
         n_push  = n_push + SUM_W'(push[d]);
      end
      drop_now = n_vld - n_push;
   end

   always_ff @(posedge clk) begin
      for (int d = 0; d < PORT_NUB; d++)
         if (push[d])
            mem[d][wr_ptr[d]] <= win_data[d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < PORT_NUB; d++) begin
            wr_ptr[d] <= '0;
            rd_ptr[d] <= '0;
            cnt[d]    <= '0;
         end
         drop_cnt <= '0;
      end else begin
         for (int d = 0; d < PORT_NUB; d++) begin
            if (push[d])
               wr_ptr[d] <= wr_ptr[d] + PTR_W'(1);
            if (pop[d])
               rd_ptr[d] <= rd_ptr[d] + PTR_W'(1);
            case ({push[d], pop[d]})
               2'b10:   cnt[d] <= cnt[d] + CNT_W'(1);
               2'b01:   cnt[d] <= cnt[d] - CNT_W'(1);
               default: cnt[d] <= cnt[d];
            endcase
         end
         drop_cnt <= sat_add(drop_cnt, drop_now);
      end
   end

   for (genvar d = 0; d < PORT_NUB; d++) begin : g_out
      assign out_valid[d] = (cnt[d] != '0);
      assign out_data[d*DATA_WIDTH +: DATA_WIDTH] = out_valid[d] ? mem[d][rd_ptr[d]] : '0;
   end

endmodule
